// File: rtl/fir_tdm_filter.sv
// Multi-channel FIR filter sharing one multiplier; optional output clamp via FIR_SATURATE_EN.
// Latency: out_valid NUM_CH*NUM_TAPS+2 edges after the accepting edge; in_ready high only in IDLE.
// Backpressure: none on the output; results are held until the next strobe.
module fir_tdm_filter #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 33,
    parameter int NUM_CH   = 2,
    parameter int SHIFT    = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_valid,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    input  logic                       coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    output logic                       coef_err
);
    localparam int AW     = $clog2(NUM_TAPS);
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              wptr, wptr_nxt, tap, rd_idx;
    logic [AW:0]                rd_sum;
    logic [CW-1:0]              ch;
    logic signed [DATA_W-1:0]   hist [NUM_CH][NUM_TAPS];
    logic signed [COEF_W-1:0]   coef [NUM_TAPS];
    logic [DATA_W-1:0]          res  [NUM_CH];
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc, acc_base, acc_next;
    logic [DATA_W-1:0]          res_val;
    logic                       accept, last_tap, last_ch, addr_ok, coef_wr, coef_rej;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last_tap = (tap == AW'(NUM_TAPS - 1));
    assign last_ch  = (ch == CW'(NUM_CH - 1));
    assign wptr_nxt = (wptr == AW'(NUM_TAPS - 1)) ? '0 : wptr + AW'(1);
    assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(NUM_TAPS));
    assign coef_wr  = coef_we && (state == IDLE) && addr_ok;
    assign coef_rej = coef_we && !((state == IDLE) && addr_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_tap && last_ch) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap k of the current channel lives at (wptr - k) mod NUM_TAPS.
    always_comb begin
        rd_sum   = {1'b0, wptr} + (AW+1)'(NUM_TAPS) - {1'b0, tap};
        rd_idx   = (rd_sum >= (AW+1)'(NUM_TAPS)) ? AW'(rd_sum - (AW+1)'(NUM_TAPS)) : AW'(rd_sum);
        prod     = coef[tap] * hist[ch][rd_idx];
        acc_base = (tap == '0) ? '0 : acc;
        acc_next = acc_base + ACC_W'(prod);
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_next >>> SHIFT;
        if (shifted > SAT_MAX)
            res_val = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            res_val = SAT_MIN[DATA_W-1:0];
        else
            res_val = shifted[DATA_W-1:0];
    end
`else
    assign res_val = DATA_W'(acc_next >>> SHIFT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            tap       <= '0;
            ch        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                res[c] <= '0;
                for (int k = 0; k < NUM_TAPS; k++)
                    hist[c][k] <= '0;
            end
            for (int k = 0; k < NUM_TAPS; k++)
                coef[k] <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            coef_err  <= coef_rej;
            if (coef_wr)
                coef[coef_addr] <= coef_wdata;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wptr <= wptr_nxt;
                        tap  <= '0;
                        ch   <= '0;
                        for (int c = 0; c < NUM_CH; c++)
                            hist[c][wptr_nxt] <= in_data[c*DATA_W +: DATA_W];
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        res[ch] <= res_val;
                        tap     <= '0;
                        ch      <= last_ch ? '0 : ch + CW'(1);
                    end else begin
                        tap <= tap + AW'(1);
                    end
                end
                DONE: begin
                    out_valid <= 1'b1;
                    for (int c = 0; c < NUM_CH; c++)
                        out_data[c*DATA_W +: DATA_W] <= res[c];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fir_tdm_filter.md
FIR_TDM_FILTER -- requirements
Module: fir_tdm_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width per channel.
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 33, filter length (2..256).
REQ-004 SHALL have parameter NUM_CH, default 2, channel count sharing one coefficient set.
REQ-005 SHALL have parameter SHIFT, default 15, arithmetic right-shift normalisation.
REQ-006 SHALL have port clk  in  1  sole clock; one clock domain.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  in  1  input frame valid.
REQ-009 SHALL have port in_ready  out  1  block can accept a frame.
REQ-010 SHALL have port in_data  in  NUM_CH*DATA_W  signed samples, ch0 in LSBs.
REQ-011 SHALL have port out_valid  out  1  one-cycle result strobe.
REQ-012 SHALL have port out_data  out  NUM_CH*DATA_W  filtered samples, ch0 in LSBs, held between strobes.
REQ-013 SHALL have port coef_we  in  1  coefficient write strobe.
REQ-014 SHALL have port coef_addr  in  clog2(NUM_TAPS)  tap index.
REQ-015 SHALL have port coef_wdata  in  COEF_W  signed coefficient.
REQ-016 SHALL have port coef_err  out  1  one-cycle pulse on a rejected write.

Function
REQ-017 SHALL implement y_c[n] = (sum over k=0..NUM_TAPS-1 of h[k]*x_c[n-k]) >>> SHIFT independently per channel, using one shared multiplier (time-multiplexed MAC).
REQ-018 SHALL use FSM states IDLE, MAC, DONE: IDLE->MAC on accept; MAC->DONE after NUM_CH*NUM_TAPS product cycles; DONE->IDLE unconditionally.
REQ-019 SHALL assert in_ready only in IDLE; a frame is accepted on a clk edge with in_valid and in_ready both high.
REQ-020 SHALL store each channel's history in a circular buffer of NUM_TAPS entries; on accept, the new sample overwrites the oldest entry and the write pointer wraps from NUM_TAPS-1 to 0.
REQ-021 SHALL read tap k from index (wptr-k) mod NUM_TAPS, processing channels in order ch0..ch(NUM_CH-1) and clearing the accumulator at each channel start.
REQ-022 SHALL size the accumulator at DATA_W+COEF_W+clog2(NUM_TAPS) signed bits, so no internal overflow occurs.
REQ-023 SHALL assert out_valid for exactly one cycle, NUM_CH*NUM_TAPS+2 clk edges after the accept edge, with in_ready high in that same cycle.
REQ-024 SHALL NOT accept backpressure on the output; out_data SHALL remain stable until the next out_valid.
REQ-025 SHALL write coefficients only in IDLE and only when coef_addr < NUM_TAPS; otherwise the write is dropped and coef_err pulses for one cycle.
REQ-026 SHALL give a frame presented in the same cycle as a coef_we write in IDLE the newly written coefficient.

Reset
REQ-027 SHALL, while rst_n is low, drive in_ready=1, out_valid=0, out_data=0, coef_err=0, FSM=IDLE, pointers=0, all delay entries=0 and all coefficients=0.
REQ-028 SHALL abandon any in-progress frame when reset asserts mid-MAC, with no out_valid for that frame.

Configuration
REQ-029 SHALL, when macro FIR_SATURATE_EN is defined, clamp each shifted result to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 SHALL, when FIR_SATURATE_EN is undefined, truncate each shifted result to its low DATA_W bits (two's-complement wrap).

Verification
REQ-031 SHALL cover impulse response: h0=16384, h1=8192, others 0; frame ch0=1000/ch1=-2000, then zero frames -> outputs (500,-1000), (250,-500), (0,0).
REQ-032 SHALL cover overflow: all h=32767; frames ch0=32767 -> 1st output 32766; 2nd output 32767 with FIR_SATURATE_EN, -4 without.
REQ-033 SHALL cover handshake timing: in_valid held high -> in_ready low during MAC/DONE, out_valid exactly 68 edges after accept (defaults), next frame accepted in the out_valid cycle.
REQ-034 SHALL cover rejected writes: coef_we during MAC, or coef_addr=33 -> coef_err one-cycle pulse, later impulse response unchanged.
REQ-035 SHALL cover reset mid-operation: rst_n low at MAC cycle 10 -> out_valid never asserts for that frame, outputs 0, in_ready=1; next frame gives out 0.
REQ-036 SHALL cover buffer wrap-around: h32=16384 only; impulse 1000 followed by 40 zero frames -> outputs 0 except output index 32 = 500.
